// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that lets NUM_REQ producers share the write
//   port of one synchronous FIFO. Each grant covers up to BURST_MAX words.
//   Writes are throttled using the FIFO full flag and occupancy count. The
//   registered write that is still in flight is counted, so no word is ever
//   dropped.
//
// Ports
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   req         : per-requester "word valid"
//   req_data    : packed words, requester i at [i*DATA_W +: DATA_W]
//   ack         : one-hot, combinational; requester's word taken this cycle
//   fifo_wr_en  : registered FIFO write enable
//   fifo_din    : registered FIFO write data
//   fifo_full   : FIFO full flag
//   fifo_count  : FIFO occupancy
//   busy        : registered, high while the FSM is in GRANT (FSM debug view)
//   owner       : registered index of the current/last granted requester
//   stall_cnt   : only with FIFO_ARB_STATS_EN; saturating count of cycles
//                 in which the owner had a word but there was no FIFO space
//
// Build option
//   FIFO_ARB_STATS_EN : adds the stall_cnt output and its counter.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int OWN_W     = 2,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int DEPTH     = 64,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  input  logic                      fifo_full,
  input  logic [CNT_W-1:0]          fifo_count,
  output logic                      busy,
  output logic [OWN_W-1:0]          owner
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int BC_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(BURST_MAX - 1);
  localparam logic [CNT_W:0]   DEPTH_V    = (CNT_W + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_W-1:0]   fifo_din_q, fifo_din_d;
  logic                busy_q, busy_d;

  logic [CNT_W:0]      occ;
  logic                space_ok;
  logic                accept;
  logic                stalled;
  logic [DATA_W-1:0]   owner_word;
  logic [OWN_W-1:0]    scan_idx;
  logic [OWN_W-1:0]    pick;
  logic                found;

  // Handshake: a producer raises req[i] and holds req_data[i] stable until
  // it sees ack[i] high in the same cycle. That cycle is the transfer.
  // ack can only go to the current owner, and only when the FIFO has space.
  always_comb begin
    occ        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, fifo_wr_en_q};
    space_ok   = !fifo_full && (occ < DEPTH_V);
    accept     = (state_q == GRANT) && req[owner_q] && space_ok;
    stalled    = (state_q == GRANT) && req[owner_q] && !space_ok;
    owner_word = req_data[owner_q*DATA_W +: DATA_W];
    ack        = accept ? (NUM_REQ'(1) << owner_q) : '0;
  end

  // Scan starts at rr_ptr. The first hit wins, so the requester just after
  // the last owner has the highest priority.
  always_comb begin
    found    = 1'b0;
    pick     = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr_q + OWN_W'(k);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    fifo_wr_en_d = accept;
    fifo_din_d   = accept ? owner_word : fifo_din_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          if (burst_cnt_q == BURST_LAST) begin
            state_d  = IDLE;
            rr_ptr_d = owner_q + 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (!req[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + 1'b1;
        end
        // Owner has a word but no space: hold the grant and burst_cnt.
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_din_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      fifo_din_q   <= fifo_din_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_wr_en = fifo_wr_en_q;
  assign fifo_din   = fifo_din_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stalled;
  assign unused_stalled = stalled;
`endif

endmodule
